// File: rtl/second_game_sprite_renderer.sv
// Sprite/obstacle compositor for a sub-window of the VGA raster, with
// per-frame sprite/obstacle collision latching and blinking of collided sprites.
module second_game_sprite_renderer #(
  parameter int START_X       = 400,
  parameter int START_Y       = 0,
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int NUM_SPRITES   = 2,
  parameter int SPRITE_HALF   = 20,
  parameter int BLINK_PERIOD  = 16,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [10:0]               i_h_coord,
  input  logic [9:0]                i_v_coord,
  input  logic                      i_disp_enbl,
  input  logic [NUM_SPRITES*XW-1:0] i_sprite_x,
  input  logic [NUM_SPRITES*YW-1:0] i_sprite_y,
  input  logic [NUM_SPRITES-1:0]    i_sprite_en,
  input  logic [NUM_SPRITES*12-1:0] i_sprite_color,
  input  logic [11:0]               i_obstacle_color,
  input  logic [11:0]               i_bkg_color,
  output logic [XW-1:0]             o_screen_x,
  output logic [YW-1:0]             o_screen_y,
  input  logic                      i_is_obstacle,
  output logic [3:0]                o_red,
  output logic [3:0]                o_green,
  output logic [3:0]                o_blue,
  output logic [NUM_SPRITES-1:0]    o_collision,
  output logic                      o_frame_done
);

  localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic signed [11:0] LX_MAX = 12'(SCREEN_WIDTH);
  localparam logic signed [11:0] LY_MAX = 12'(SCREEN_HEIGHT);
  localparam logic signed [12:0] HALF_P = 13'(SPRITE_HALF);
  localparam logic signed [12:0] HALF_N = -HALF_P;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PERIOD / 2);

  logic signed [11:0]     w_lx, w_ly;
  logic                   w_in_win;
  logic signed [12:0]     w_dx, w_dy;
  logic [NUM_SPRITES-1:0] w_hit;
  logic [NUM_SPRITES-1:0] w_col;
  logic [NUM_SPRITES-1:0] w_vis;
  logic [11:0]            w_rgb;
  logic                   w_is00, w_bnd;

  logic                   r_vld_p1;
  logic [NUM_SPRITES-1:0] r_hit_p1;
  logic [11:0]            r_rgb_p2;
  logic [NUM_SPRITES-1:0] r_acc;
  logic [NUM_SPRITES-1:0] r_coll;
  logic                   r_frame_done;
  logic [BW-1:0]          r_blink;
  logic                   r_is00;

  assign w_lx     = {1'b0, i_h_coord} - 12'(START_X);
  assign w_ly     = {2'b0, i_v_coord} - 12'(START_Y);
  assign w_in_win = (w_lx >= 12'sd0) && (w_lx < LX_MAX) &&
                    (w_ly >= 12'sd0) && (w_ly < LY_MAX);

  assign o_screen_x = w_lx[XW-1:0];
  assign o_screen_y = w_ly[YW-1:0];

  // 13-bit differences keep a guard bit so far-away sprites never wrap into range
  always_comb begin
    w_hit = '0;
    w_dx  = '0;
    w_dy  = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      w_dx = 13'(w_lx) - 13'(i_sprite_x[k*XW +: XW]);
      w_dy = 13'(w_ly) - 13'(i_sprite_y[k*YW +: YW]);
      w_hit[k] = i_sprite_en[k] && (w_dx >= HALF_N) && (w_dx <= HALF_P) &&
                 (w_dy >= HALF_N) && (w_dy <= HALF_P);
    end
  end

  // ---- stage 1 -> stage 2: obstacle map answer arrives alongside r_*_p1 ----
  assign w_col = {NUM_SPRITES{r_vld_p1 & i_is_obstacle}} & r_hit_p1;

  always_comb begin
    for (int k = 0; k < NUM_SPRITES; k++)
      w_vis[k] = r_hit_p1[k] & ~(r_coll[k] & (r_blink >= BLINK_HALF));
  end

  always_comb begin
    w_rgb = 12'h000;
    if (r_vld_p1) begin
      w_rgb = i_is_obstacle ? i_obstacle_color : i_bkg_color;
      for (int k = NUM_SPRITES - 1; k >= 0; k--)
        if (w_vis[k]) w_rgb = i_sprite_color[k*12 +: 12];
    end
  end

  assign w_is00 = (i_h_coord == 11'd0) && (i_v_coord == 10'd0);
  assign w_bnd  = w_is00 & ~r_is00;

  always_ff @(posedge i_clk) begin
    r_hit_p1 <= w_hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1     <= 1'b0;
      r_rgb_p2     <= 12'h000;
      r_acc        <= '0;
      r_coll       <= '0;
      r_frame_done <= 1'b0;
      r_blink      <= '0;
      r_is00       <= 1'b0;
    end else begin
      r_vld_p1     <= i_disp_enbl & w_in_win;
      r_rgb_p2     <= w_rgb;
      r_is00       <= w_is00;
      r_frame_done <= w_bnd;
      if (w_bnd) begin
        // the stage-1 pixel still belongs to the frame that is closing
        r_coll  <= r_acc | w_col;
        r_acc   <= '0;
        r_blink <= (r_blink == BLINK_LAST) ? '0 : r_blink + 1'b1;
      end else begin
        r_acc <= r_acc | w_col;
      end
    end
  end

  assign o_red        = r_rgb_p2[11:8];
  assign o_green      = r_rgb_p2[7:4];
  assign o_blue       = r_rgb_p2[3:0];
  assign o_collision  = r_coll;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/second_game_sprite_renderer.md
SECOND_GAME_SPRITE_RENDERER -- requirements
Module: second_game_sprite_renderer

Interface
REQ-001 SHALL have parameters (name, default, meaning): START_X, 400, window left edge in VGA pixels.
REQ-002 SHALL have parameter START_Y, 0, window top edge.
REQ-003 SHALL have parameter SCREEN_WIDTH, 400, window width; XW = $clog2(SCREEN_WIDTH).
REQ-004 SHALL have parameter SCREEN_HEIGHT, 600, window height; YW = $clog2(SCREEN_HEIGHT).
REQ-005 SHALL have parameter NUM_SPRITES, 2, sprite count (1..8).
REQ-006 SHALL have parameter SPRITE_HALF, 20, sprite half-size; box is inclusive +/-SPRITE_HALF about centre.
REQ-007 SHALL have parameter BLINK_PERIOD, 16, blink period in frames (even, >=2).
REQ-008 SHALL have a single clock and a synchronous, active-high reset, with ports: i_clk  in  1  clock; i_rst  in  1  reset.
REQ-009 SHALL have ports i_h_coord in 11, i_v_coord in 10, i_disp_enbl in 1: VGA raster position and display enable.
REQ-010 SHALL have ports i_sprite_x in NUM_SPRITES*XW and i_sprite_y in NUM_SPRITES*YW: packed sprite centres, sprite k at slice k.
REQ-011 SHALL have ports i_sprite_en in NUM_SPRITES (per-sprite enable) and i_sprite_color in NUM_SPRITES*12 (RGB444).
REQ-012 SHALL have ports i_obstacle_color in 12 and i_bkg_color in 12.
REQ-013 SHALL have ports o_screen_x out XW and o_screen_y out YW (obstacle map lookup address), and i_is_obstacle in 1 (map result, valid one cycle after address).
REQ-014 SHALL have ports o_red, o_green, o_blue out 4 each: registered colour.
REQ-015 SHALL have ports o_collision out NUM_SPRITES (per-sprite collision latched for the last frame) and o_frame_done out 1 (one-cycle frame-end pulse).

Function
REQ-016 SHALL compute local lx = i_h_coord - START_X and ly = i_v_coord - START_Y in 12-bit signed arithmetic; in_win = 0<=lx<SCREEN_WIDTH and 0<=ly<SCREEN_HEIGHT.
REQ-017 SHALL drive o_screen_x = lx[XW-1:0] and o_screen_y = ly[YW-1:0] combinationally from the current inputs (cycle t).
REQ-018 SHALL compute hit[k] = i_sprite_en[k] and |lx - x_k| <= SPRITE_HALF and |ly - y_k| <= SPRITE_HALF, signed with a guard bit, no wrap; boxes crossing a window edge are clipped by in_win.
REQ-019 Stage 1 (register at end of cycle t) SHALL hold disp_enbl, in_win and hit[] for the pixel at t.
REQ-020 Stage 2 (register at end of cycle t+1) SHALL select colour using i_is_obstacle sampled at t+1; RGB latency is exactly 2 cycles.
REQ-021 Colour priority: disp_enbl=0 or in_win=0 -> 12'h000; else lowest-index visible hit sprite colour; else i_obstacle_color if obstacle; else i_bkg_color.
REQ-022 Sprite k SHALL be invisible when o_collision[k]=1 and blink_cnt >= BLINK_PERIOD/2; otherwise visible when hit.
REQ-023 Collision event col[k] at stage 1 = disp_enbl and in_win and hit[k] and i_is_obstacle, independent of blink visibility.
REQ-024 SHALL OR col[] into a per-frame accumulator acc[].
REQ-025 Frame boundary: cycle where i_h_coord==0 and i_v_coord==0; at that cycle o_collision <= acc | col (the stage-1 pixel belongs to the old frame), acc <= 0, o_frame_done <= 1 next cycle for exactly one cycle.
REQ-026 blink_cnt SHALL increment at each frame boundary, wrapping BLINK_PERIOD-1 -> 0.
REQ-027 Boundary held for consecutive cycles SHALL be treated as one frame only on its first cycle (edge-detect).

Reset
REQ-028 While i_rst=1 at a clock edge: RGB=0, o_collision=0, o_frame_done=0, acc=0, blink_cnt=0, pipeline valid bits cleared; o_screen_x/y remain combinational.
REQ-029 Reset mid-frame SHALL discard accumulated collisions; the first boundary after reset latches only post-reset events.

Verification
REQ-030 Sprite0 at (100,100), en=1, colour 12'hF00, no obstacle, bkg 12'h00F: raster (500,100) -> RGB 12'hF00 two cycles later; (521,100) -> 12'h00F.
REQ-031 Raster h=399 or v outside window with disp_enbl=1 -> RGB 12'h000; o_screen_x = lx low bits.
REQ-032 Two sprites overlapping at (200,300), colours 12'h0F0 (k=0) and 12'hFF0 (k=1) -> RGB 12'h0F0.
REQ-033 Obstacle returned at sprite1 pixel during frame -> at next (0,0) o_collision=2'b10, o_frame_done pulses once; following frame without overlap -> o_collision=2'b00.
REQ-034 With o_collision[0]=1, sprite0 drawn for frames blink_cnt 0..7, shows bkg/obstacle for 8..15 (BLINK_PERIOD=16).
REQ-035 Assert i_rst after a collision mid-frame -> RGB 0, acc cleared, next boundary yields o_collision=0.
